// File: rtl/byte_rx_align.sv
// Serial receive aligner: finds COM-delimited byte boundaries in an MSB-first bit stream and delivers bytes once locked.
// Optional macro STRIP_COM_EN: suppress delivery of COM bytes while locked.
module byte_rx_align #(
    parameter logic [7:0]  COM      = 8'hBC,
    parameter int unsigned COM_LOCK = 4,
    parameter int unsigned IDLE_MAX = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       SER_IN,
    output logic [7:0] DATA_out,
    output logic       BYTE_STB,
    output logic       Valid_out,
    output logic [1:0] STATE
);

    localparam int unsigned BitCntW  = 3;
    localparam int unsigned ComCntW  = 3;
    localparam int unsigned IdleCntW = 4;

`ifdef STRIP_COM_EN
    localparam bit StripCom = 1'b1;
`else
    localparam bit StripCom = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_SEARCH = 2'd0,
        S_ALIGN  = 2'd1,
        S_ACTIVE = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [6:0]            sr_q, sr_d;
    logic [BitCntW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [ComCntW-1:0]    com_cnt_q, com_cnt_d;
    logic [IdleCntW-1:0]   idle_cnt_q, idle_cnt_d;
    logic [7:0]            data_q, data_d;
    logic                  stb_q, stb_d;
    logic                  valid_q, valid_d;
    logic [7:0]            nb;

    // Byte completed at this edge
    assign nb = {sr_q, SER_IN};

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= S_SEARCH;
            sr_q       <= '0;
            bit_cnt_q  <= '0;
            com_cnt_q  <= '0;
            idle_cnt_q <= '0;
            data_q     <= '0;
            stb_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            bit_cnt_q  <= bit_cnt_d;
            com_cnt_q  <= com_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            data_q     <= data_d;
            stb_q      <= stb_d;
            valid_q    <= valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sr_d       = nb[6:0];
        bit_cnt_d  = bit_cnt_q + BitCntW'(1);
        com_cnt_d  = com_cnt_q;
        idle_cnt_d = idle_cnt_q;
        data_d     = data_q;
        stb_d      = 1'b0;

        unique case (state_q)
            S_SEARCH: begin
                bit_cnt_d = '0;
                if (nb == COM) begin
                    // A single-COM lock skips the ALIGN phase entirely
                    if (COM_LOCK == 32'd1) begin
                        state_d    = S_ACTIVE;
                        idle_cnt_d = '0;
                    end else begin
                        state_d   = S_ALIGN;
                        com_cnt_d = ComCntW'(1);
                    end
                end
            end
            S_ALIGN: begin
                if (bit_cnt_q == BitCntW'(7)) begin
                    if (nb == COM) begin
                        if (com_cnt_q + ComCntW'(1) == ComCntW'(COM_LOCK)) begin
                            state_d    = S_ACTIVE;
                            idle_cnt_d = '0;
                        end else begin
                            com_cnt_d = com_cnt_q + ComCntW'(1);
                        end
                    end else begin
                        state_d   = S_SEARCH;
                        com_cnt_d = '0;
                        bit_cnt_d = '0;
                    end
                end
            end
            S_ACTIVE: begin
                if (bit_cnt_q == BitCntW'(7)) begin
                    if (nb == 8'h00) begin
                        if (idle_cnt_q + IdleCntW'(1) == IdleCntW'(IDLE_MAX)) begin
                            state_d    = S_SEARCH;
                            bit_cnt_d  = '0;
                            com_cnt_d  = '0;
                            idle_cnt_d = '0;
                        end else begin
                            idle_cnt_d = idle_cnt_q + IdleCntW'(1);
                            data_d     = nb;
                            stb_d      = 1'b1;
                        end
                    end else begin
                        idle_cnt_d = '0;
                        if (!(StripCom && nb == COM)) begin
                            data_d = nb;
                            stb_d  = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d   = S_SEARCH;
                bit_cnt_d = '0;
                com_cnt_d = '0;
            end
        endcase

        valid_d = (state_d == S_ACTIVE);
    end

    assign DATA_out  = data_q;
    assign BYTE_STB  = stb_q;
    assign Valid_out = valid_q;
    assign STATE     = state_q;

endmodule

// File: tb/tb_byte_rx_align.sv
// Directed self-checking bench for byte_rx_align; honours STRIP_COM_EN the same way as the design.
module tb_byte_rx_align;

    logic       CLK;
    logic       RESET;
    logic       SER_IN;
    logic [7:0] DATA_out;
    logic       BYTE_STB;
    logic       Valid_out;
    logic [1:0] STATE;

    int checks;
    int errors;
    int nstb;
    int pos;

    byte_rx_align dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .SER_IN    (SER_IN),
        .DATA_out  (DATA_out),
        .BYTE_STB  (BYTE_STB),
        .Valid_out (Valid_out),
        .STATE     (STATE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one bit and sample 1 time unit after the edge that captures it
    task automatic send_bit(input logic b);
        SER_IN = b;
        @(posedge CLK);
        #1;
    endtask

    // Send a byte MSB first; count strobes and record the bit index where the last one appeared
    task automatic send_byte(input logic [7:0] v, output int n, output int p);
        n = 0;
        p = -1;
        for (int i = 7; i >= 0; i--) begin
            send_bit(v[i]);
            if (BYTE_STB) begin
                n++;
                p = 7 - i;
            end
        end
    endtask

    // Send a byte and check strobe count/position, held data and valid level
    task automatic byte_chk(input string tag, input logic [7:0] v, input int exp_n,
                            input logic [7:0] exp_d, input logic exp_v, input logic [1:0] exp_s);
        int n;
        int p;
        send_byte(v, n, p);
        chk({tag, ".stb_cnt"}, 32'(n), 32'(exp_n));
        if (exp_n == 1) chk({tag, ".stb_pos"}, 32'(p), 32'd7);
        chk({tag, ".data"},  32'(DATA_out),  32'(exp_d));
        chk({tag, ".valid"}, 32'(Valid_out), 32'(exp_v));
        chk({tag, ".state"}, 32'(STATE),     32'(exp_s));
    endtask

    task automatic do_reset(input int cycles);
        RESET = 1'b0;
        repeat (cycles) @(posedge CLK);
        #1;
        RESET = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        SER_IN = 1'b0;
        RESET  = 1'b0;

        // Reset state held for 32 cycles
        repeat (32) @(posedge CLK);
        #1;
        chk("rst.data",  32'(DATA_out),  32'h00);
        chk("rst.stb",   32'(BYTE_STB),  32'd0);
        chk("rst.valid", 32'(Valid_out), 32'd0);
        chk("rst.state", 32'(STATE),     32'd0);
        RESET = 1'b1;

        // Reset then stream
        byte_chk("s1.b25", 8'h25, 0, 8'h00, 1'b0, 2'd0);
        byte_chk("s1.com1", 8'hBC, 0, 8'h00, 1'b0, 2'd1);
        byte_chk("s1.com2", 8'hBC, 0, 8'h00, 1'b0, 2'd1);
        byte_chk("s1.com3", 8'hBC, 0, 8'h00, 1'b0, 2'd1);
        byte_chk("s1.com4", 8'hBC, 0, 8'h00, 1'b1, 2'd2);
        byte_chk("s1.bF9", 8'hF9, 1, 8'hF9, 1'b1, 2'd2);
        byte_chk("s1.b4F", 8'h4F, 1, 8'h4F, 1'b1, 2'd2);
        byte_chk("s1.bA6", 8'hA6, 1, 8'hA6, 1'b1, 2'd2);

        // Arbitrary bit offset
        do_reset(4);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        chk("s2.junk.state", 32'(STATE), 32'd0);
        byte_chk("s2.com1", 8'hBC, 0, 8'h00, 1'b0, 2'd1);
        byte_chk("s2.com2", 8'hBC, 0, 8'h00, 1'b0, 2'd1);
        byte_chk("s2.com3", 8'hBC, 0, 8'h00, 1'b0, 2'd1);
        byte_chk("s2.com4", 8'hBC, 0, 8'h00, 1'b1, 2'd2);
        byte_chk("s2.b39", 8'h39, 1, 8'h39, 1'b1, 2'd2);

        // Lock abort, then relock
        do_reset(4);
        byte_chk("s3.com1", 8'hBC, 0, 8'h00, 1'b0, 2'd1);
        byte_chk("s3.com2", 8'hBC, 0, 8'h00, 1'b0, 2'd1);
        byte_chk("s3.b25", 8'h25, 0, 8'h00, 1'b0, 2'd0);
        byte_chk("s3.com3", 8'hBC, 0, 8'h00, 1'b0, 2'd1);
        byte_chk("s3.com4", 8'hBC, 0, 8'h00, 1'b0, 2'd1);
        byte_chk("s3.com5", 8'hBC, 0, 8'h00, 1'b0, 2'd1);
        byte_chk("s3.com6", 8'hBC, 0, 8'h00, 1'b1, 2'd2);
        byte_chk("s3.bA8", 8'hA8, 1, 8'hA8, 1'b1, 2'd2);

        // Idle run shorter than the limit holds lock
        byte_chk("s4.z1", 8'h00, 1, 8'h00, 1'b1, 2'd2);
        byte_chk("s4.z2", 8'h00, 1, 8'h00, 1'b1, 2'd2);
        byte_chk("s4.z3", 8'h00, 1, 8'h00, 1'b1, 2'd2);
        byte_chk("s4.b55", 8'h55, 1, 8'h55, 1'b1, 2'd2);
        byte_chk("s4.z4", 8'h00, 1, 8'h00, 1'b1, 2'd2);
        byte_chk("s4.z5", 8'h00, 1, 8'h00, 1'b1, 2'd2);
        byte_chk("s4.z6", 8'h00, 1, 8'h00, 1'b1, 2'd2);

        // Idle loss: fourth consecutive zero drops lock without a strobe
        byte_chk("s5.b11", 8'h11, 1, 8'h11, 1'b1, 2'd2);
        byte_chk("s5.z1", 8'h00, 1, 8'h00, 1'b1, 2'd2);
        byte_chk("s5.z2", 8'h00, 1, 8'h00, 1'b1, 2'd2);
        byte_chk("s5.z3", 8'h00, 1, 8'h00, 1'b1, 2'd2);
        byte_chk("s5.z4", 8'h00, 0, 8'h00, 1'b0, 2'd0);
        byte_chk("s5.after", 8'h77, 0, 8'h00, 1'b0, 2'd0);

        // Relock, then asynchronous reset 4 bits into a byte
        byte_chk("s6.com1", 8'hBC, 0, 8'h00, 1'b0, 2'd1);
        byte_chk("s6.com2", 8'hBC, 0, 8'h00, 1'b0, 2'd1);
        byte_chk("s6.com3", 8'hBC, 0, 8'h00, 1'b0, 2'd1);
        byte_chk("s6.com4", 8'hBC, 0, 8'h00, 1'b1, 2'd2);
        byte_chk("s6.bF9", 8'hF9, 1, 8'hF9, 1'b1, 2'd2);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        #3;
        RESET = 1'b0;
        #1;
        chk("s6.arst.data",  32'(DATA_out),  32'h00);
        chk("s6.arst.stb",   32'(BYTE_STB),  32'd0);
        chk("s6.arst.valid", 32'(Valid_out), 32'd0);
        chk("s6.arst.state", 32'(STATE),     32'd0);
        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b1;
        byte_chk("s6.re1", 8'hBC, 0, 8'h00, 1'b0, 2'd1);
        byte_chk("s6.re2", 8'hBC, 0, 8'h00, 1'b0, 2'd1);
        byte_chk("s6.re3", 8'hBC, 0, 8'h00, 1'b0, 2'd1);
        byte_chk("s6.re4", 8'hBC, 0, 8'h00, 1'b1, 2'd2);

        // COM delivery while locked
        byte_chk("s7.bF9", 8'hF9, 1, 8'hF9, 1'b1, 2'd2);
`ifdef STRIP_COM_EN
        byte_chk("s7.com", 8'hBC, 0, 8'hF9, 1'b1, 2'd2);
`else
        byte_chk("s7.com", 8'hBC, 1, 8'hBC, 1'b1, 2'd2);
`endif
        byte_chk("s7.b4F", 8'h4F, 1, 8'h4F, 1'b1, 2'd2);

        // Misaligned COM while locked is plain data: no realignment
        send_byte(8'h0B, nstb, pos);
        chk("s8.b0B.stb_cnt", 32'(nstb), 32'd1);
        chk("s8.b0B.data", 32'(DATA_out), 32'h0B);
        send_byte(8'hC0, nstb, pos);
        chk("s8.bC0.stb_cnt", 32'(nstb), 32'd1);
        chk("s8.bC0.data", 32'(DATA_out), 32'hC0);
        chk("s8.state", 32'(STATE), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
